// File: rtl/fetch_queue.sv
`default_nettype none
// ==========================================================================
// fetch_queue : fetch-to-decode instruction FIFO with flush (optional
// same-cycle bypass when FETCH_QUEUE_BYPASS_EN is defined).  Rev 1.0
// ==========================================================================
module fetch_queue #(
  parameter int N     = 64,
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_valid_F,
  input  logic [N-1:0]             enq_pc_F,
  input  logic [W-1:0]             enq_instr_F,
  output logic                     enq_ready_F,
  output logic                     deq_valid_D,
  output logic [N-1:0]             deq_pc_D,
  output logic [W-1:0]             deq_instr_D,
  input  logic                     deq_ready_D,
  input  logic                     flush_D,
  output logic [$clog2(DEPTH):0]   count_D
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [N-1:0]  pc_mem    [DEPTH];
  logic [W-1:0]  instr_mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic          has_entry;
  logic          bypass;
  logic          enq_fire;
  logic          deq_fire;

  assign has_entry   = (count != '0);
  assign enq_ready_F = (count < CAP);
  assign count_D     = count;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue forwards the fetch entry straight to decode.
  assign bypass = !has_entry && enq_valid_F && !flush_D;

  always_comb begin
    deq_pc_D    = '0;
    deq_instr_D = '0;
    if (has_entry) begin
      deq_pc_D    = pc_mem[head];
      deq_instr_D = instr_mem[head];
    end else if (bypass) begin
      deq_pc_D    = enq_pc_F;
      deq_instr_D = enq_instr_F;
    end
  end
`else
  assign bypass = 1'b0;

  always_comb begin
    deq_pc_D    = '0;
    deq_instr_D = '0;
    if (has_entry) begin
      deq_pc_D    = pc_mem[head];
      deq_instr_D = instr_mem[head];
    end
  end
`endif

  assign deq_valid_D = has_entry || bypass;

  // A bypassed entry consumed by decode never touches storage.
  assign enq_fire = enq_valid_F && enq_ready_F && !flush_D && !(bypass && deq_ready_D);
  assign deq_fire = has_entry && deq_ready_D && !flush_D;

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      pc_mem[tail]    <= enq_pc_F;
      instr_mem[tail] <= enq_instr_F;
    end
  end

  // Pointer width is log2(DEPTH), so natural overflow gives modulo-DEPTH wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_D) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) tail <= tail + 1'b1;
      if (deq_fire) head <= head + 1'b1;
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ==========================================================================
// tb_fetch_queue : queue-model scoreboard plus directed scenarios. Rev 1.0
// ==========================================================================
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        enq_valid_F;
  logic [63:0] enq_pc_F;
  logic [31:0] enq_instr_F;
  logic        enq_ready_F;
  logic        deq_valid_D;
  logic [63:0] deq_pc_D;
  logic [31:0] deq_instr_D;
  logic        deq_ready_D;
  logic        flush_D;
  logic [2:0]  count_D;

  int compared   = 0;
  int mismatched = 0;
  bit run_chk    = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t mq[$];

  fetch_queue #(.N(64), .W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .enq_valid_F(enq_valid_F), .enq_pc_F(enq_pc_F), .enq_instr_F(enq_instr_F),
    .enq_ready_F(enq_ready_F),
    .deq_valid_D(deq_valid_D), .deq_pc_D(deq_pc_D), .deq_instr_D(deq_instr_D),
    .deq_ready_D(deq_ready_D), .flush_D(flush_D), .count_D(count_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit bypass_now(input int n);
`ifdef FETCH_QUEUE_BYPASS_EN
    return (n == 0) && enq_valid_F && !flush_D;
`else
    return (n < 0);
`endif
  endfunction

  function automatic logic [31:0] ins_of(input logic [63:0] pc);
    return {pc[15:0] ^ 16'hBEEF, pc[15:0]};
  endfunction

  // Reference model: an ordered list of entries, updated per clock edge.
  always @(negedge reset) mq.delete();

  always @(posedge clk) begin : model_upd
    int n;
    bit bp, do_enq, do_deq;
    n = mq.size();
    if (!reset || flush_D) begin
      mq.delete();
    end else begin
      bp     = bypass_now(n);
      do_deq = (n > 0) && deq_ready_D;
      do_enq = enq_valid_F && (n < DEPTH) && !(bp && deq_ready_D);
      if (do_deq) void'(mq.pop_front());
      if (do_enq) mq.push_back('{pc: enq_pc_F, instr: enq_instr_F});
    end
  end

  always @(negedge clk) begin : model_cmp
    int n;
    bit bp;
    logic [63:0] epc;
    logic [31:0] eins;
    if (reset && run_chk) begin
      n    = mq.size();
      bp   = bypass_now(n);
      epc  = 64'd0;
      eins = 32'd0;
      if (n > 0) begin
        epc  = mq[0].pc;
        eins = mq[0].instr;
      end else if (bp) begin
        epc  = enq_pc_F;
        eins = enq_instr_F;
      end
      chk("model_enq_ready", enq_ready_F, n < DEPTH);
      chk("model_deq_valid", deq_valid_D, (n > 0) || bp);
      chk("model_deq_pc", deq_pc_D, epc);
      chk("model_deq_instr", deq_instr_D, eins);
      chk("model_count", count_D, n);
    end
  end

  task automatic set_in(input bit ev, input logic [63:0] pc, input bit dr, input bit fl);
    enq_valid_F = ev;
    enq_pc_F    = ev ? pc : 64'd0;
    enq_instr_F = ev ? ins_of(pc) : 32'd0;
    deq_ready_D = dr;
    flush_D     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] pc);
    set_in(1'b1, pc, 1'b0, 1'b0);
    tick();
  endtask

  task automatic pop_expect(input logic [63:0] pc);
    set_in(1'b0, 64'd0, 1'b1, 1'b0);
    #1;
    chk("pop_valid", deq_valid_D, 1);
    chk("pop_pc", deq_pc_D, pc);
    chk("pop_instr", deq_instr_D, ins_of(pc));
    tick();
  endtask

  initial begin : stim
    logic [63:0] got[$];
    logic [2:0]  steady_cnt;
    reset = 1'b0;
    set_in(1'b0, 64'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", count_D, 0);
    chk("rst_enq_ready", enq_ready_F, 1);
    chk("rst_deq_valid", deq_valid_D, 0);
    chk("rst_deq_pc", deq_pc_D, 0);
    chk("rst_deq_instr", deq_instr_D, 0);
    reset   = 1'b1;
    run_chk = 1'b1;
    tick();

    // Fill with decode stalled, then drain in order.
    for (int i = 0; i < 4; i++) push(64'(i * 4));
    set_in(1'b0, 64'd0, 1'b0, 1'b0);
    #1;
    chk("fill_count", count_D, 4);
    chk("fill_enq_ready", enq_ready_F, 0);
    for (int i = 0; i < 4; i++) pop_expect(64'(i * 4));
    set_in(1'b0, 64'd0, 1'b0, 1'b0);
    #1;
    chk("drained_count", count_D, 0);

    // Enqueue-to-decode latency.
    set_in(1'b1, 64'h80, 1'b1, 1'b0);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("lat_same_valid", deq_valid_D, 1);
    chk("lat_same_pc", deq_pc_D, 64'h80);
`else
    chk("lat_same_valid", deq_valid_D, 0);
    chk("lat_same_pc", deq_pc_D, 0);
`endif
    tick();
    set_in(1'b0, 64'd0, 1'b1, 1'b0);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("lat_next_count", count_D, 0);
    chk("lat_next_valid", deq_valid_D, 0);
`else
    chk("lat_next_count", count_D, 1);
    chk("lat_next_pc", deq_pc_D, 64'h80);
`endif
    tick();

    // Streaming: one in, one out per cycle across pointer wrap.
`ifdef FETCH_QUEUE_BYPASS_EN
    steady_cnt = 3'd0;
`else
    steady_cnt = 3'd1;
`endif
    for (int k = 0; k < 10; k++) begin
      set_in(1'b1, 64'h100 + 64'(4 * k), 1'b1, 1'b0);
      #1;
      if (deq_valid_D) got.push_back(deq_pc_D);
      tick();
      chk("stream_count", count_D, steady_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      set_in(1'b0, 64'd0, 1'b1, 1'b0);
      #1;
      if (deq_valid_D) got.push_back(deq_pc_D);
      tick();
    end
    chk("stream_len", got.size(), 10);
    for (int k = 0; k < got.size() && k < 10; k++)
      chk("stream_order", got[k], 64'h100 + 64'(4 * k));

    // Flush with a same-cycle enqueue at count 3.
    push(64'h300); push(64'h304); push(64'h308);
    set_in(1'b1, 64'h3F0, 1'b0, 1'b1);
    #1;
    chk("flush_pre_count", count_D, 3);
    chk("flush_hold_ready", enq_ready_F, 1);
    chk("flush_hold_valid", deq_valid_D, 1);
    tick();
    set_in(1'b0, 64'd0, 1'b0, 1'b0);
    #1;
    chk("flush_count", count_D, 0);
    chk("flush_valid", deq_valid_D, 0);
    chk("flush_instr", deq_instr_D, 0);
    push(64'h200); push(64'h204);
    pop_expect(64'h200);
    pop_expect(64'h204);

    // Dequeue on full frees a slot without admitting the offered entry.
    for (int i = 0; i < 4; i++) push(64'h500 + 64'(4 * i));
    set_in(1'b1, 64'h5F0, 1'b1, 1'b0);
    #1;
    chk("full_ready", enq_ready_F, 0);
    tick();
    set_in(1'b0, 64'd0, 1'b0, 1'b0);
    #1;
    chk("full_deq_count", count_D, 3);
    chk("full_deq_ready", enq_ready_F, 1);
    pop_expect(64'h504); pop_expect(64'h508); pop_expect(64'h50C);
    set_in(1'b0, 64'd0, 1'b0, 1'b0);
    #1;
    chk("full_no_extra", deq_valid_D, 0);

    // Asynchronous reset mid-stream.
    push(64'h600); push(64'h604);
    set_in(1'b0, 64'd0, 1'b0, 1'b0);
    #1;
    chk("pre_rst_count", count_D, 2);
    reset = 1'b0;
    #1;
    chk("async_rst_count", count_D, 0);
    chk("async_rst_valid", deq_valid_D, 0);
    chk("async_rst_pc", deq_pc_D, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    push(64'h40); push(64'h44);
    pop_expect(64'h40);
    pop_expect(64'h44);

    set_in(1'b0, 64'd0, 1'b0, 1'b0);
    tick();
    run_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
